ifetch_buf: RTL and testbench

Parametrised instruction-fetch unit with a pipelined, split request/response instruction bus and an in-order prefetch FIFO. It sits between the branch/flush logic and decode. It keeps up to MAX_OUTSTANDING fetches in flight, buffers returned instructions, and hands them to decode with a valid/ready handshake in place of a stall input. It discards stale responses after any redirect.

---
 rtl/ifetch_buf.sv | 167 ++++++++++++++++
 tb/tb_ifetch_buf.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// Instruction-fetch unit: pipelined split-transaction bus front end feeding an in-order prefetch FIFO.
// Optional macro IFETCH_ERR_EN keeps a per-entry bus error flag and presents it on O_inst_err.
module ifetch_buf #(
    parameter int              ADDR_W          = 32,
    parameter int              INST_W          = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC      = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_flush,
    input  logic [ADDR_W-1:0] I_flush_addr,
    input  logic              I_bru_taken,
    input  logic [ADDR_W-1:0] I_bru_target,
    input  logic              I_jtag_halt,
    output logic              O_inst_valid,
    output logic [INST_W-1:0] O_inst,
    output logic [ADDR_W-1:0] O_inst_addr,
    output logic              O_inst_err,
    input  logic              I_inst_ready,
    output logic              O_ibus_req,
    output logic [ADDR_W-1:0] O_ibus_addr,
    input  logic              I_ibus_gnt,
    input  logic              I_ibus_rvalid,
    input  logic [INST_W-1:0] I_ibus_rdata,
    input  logic              I_ibus_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = FW + 1;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              halt_q;
    logic [CW-1:0]     live_q, live_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [QW-1:0]     aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    logic [PW-1:0]     fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [FW-1:0]     fifo_cnt_q, fifo_cnt_d;

    logic [ADDR_W-1:0] aq_mem_q    [MAX_OUTSTANDING];
    logic [INST_W-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              grant;
    logic              rsp_drop, rsp_live, rsp_any;
    logic              push, pop;
    logic [SW-1:0]     inflight, occupancy;

    assign redirect     = I_flush | I_bru_taken;
    assign redirect_tgt = (I_flush ? I_flush_addr : I_bru_target) & ~ADDR_W'(3);
    assign grant        = O_ibus_req & I_ibus_gnt;
    assign rsp_drop     = I_ibus_rvalid & (drop_q != '0);
    assign rsp_live     = I_ibus_rvalid & (drop_q == '0) & (live_q != '0);
    assign rsp_any      = rsp_drop | rsp_live;
    assign push         = rsp_live & ~redirect;
    assign pop          = O_inst_valid & I_inst_ready & ~redirect;

    // Issue only while every possible response already has a reserved FIFO slot.
    assign inflight   = SW'(live_q) + SW'(drop_q);
    assign occupancy  = SW'(live_q) + SW'(fifo_cnt_q);
    assign O_ibus_req = ~halt_q & (inflight < SW'(MAX_OUTSTANDING))
                                & (occupancy < SW'(FIFO_DEPTH));
    assign O_ibus_addr = fpc_q;

    assign O_inst_valid = (fifo_cnt_q != '0);
    assign O_inst       = O_inst_valid ? fifo_inst_q[fifo_rd_q] : '0;
    assign O_inst_addr  = O_inst_valid ? fifo_pc_q[fifo_rd_q] : '0;

    always_comb begin
        fpc_d      = fpc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;

        if (grant) begin
            aq_wr_d = (aq_wr_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : aq_wr_q + QW'(1);
        end
        if (rsp_any) begin
            aq_rd_d = (aq_rd_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : aq_rd_q + QW'(1);
        end

        // A redirect turns every wanted request, including this cycle's grant, into one to discard.
        if (redirect) begin
            fpc_d      = redirect_tgt;
            live_d     = '0;
            drop_d     = drop_q + live_q + CW'(grant) - CW'(rsp_live) - CW'(rsp_drop);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (grant) begin
                fpc_d = fpc_q + ADDR_W'(4);
            end
            live_d     = live_q + CW'(grant) - CW'(rsp_live);
            drop_d     = drop_q - CW'(rsp_drop);
            fifo_cnt_d = fifo_cnt_q + FW'(push) - FW'(pop);
            if (push) begin
                fifo_wr_d = fifo_wr_q + PW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            halt_q     <= 1'b1;
            live_q     <= '0;
            drop_q     <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            halt_q     <= I_jtag_halt;
            live_q     <= live_d;
            drop_q     <= drop_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            aq_mem_q[aq_wr_q] <= fpc_q;
        end
        if (push) begin
            fifo_inst_q[fifo_wr_q] <= I_ibus_rdata;
            fifo_pc_q[fifo_wr_q]   <= aq_mem_q[aq_rd_q];
        end
    end

`ifdef IFETCH_ERR_EN
    logic fifo_err_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_err_q[fifo_wr_q] <= I_ibus_err;
        end
    end

    assign O_inst_err = O_inst_valid & fifo_err_q[fifo_rd_q];
`else
    logic unused_err;

    assign unused_err = I_ibus_err;
    assign O_inst_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: queue-based reference model, bus responder and directed scenarios.
module tb_ifetch_buf;

    localparam int          ADDR_W     = 32;
    localparam int          INST_W     = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] ERR_PC     = 32'h8000_0008;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              I_flush, I_bru_taken, I_jtag_halt, I_inst_ready, I_ibus_gnt;
    logic [ADDR_W-1:0] I_flush_addr, I_bru_target;
    logic              I_ibus_rvalid, I_ibus_err;
    logic [INST_W-1:0] I_ibus_rdata;
    logic              O_inst_valid, O_inst_err, O_ibus_req;
    logic [INST_W-1:0] O_inst;
    logic [ADDR_W-1:0] O_inst_addr, O_ibus_addr;

    ifetch_buf #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .I_flush(I_flush), .I_flush_addr(I_flush_addr),
        .I_bru_taken(I_bru_taken), .I_bru_target(I_bru_target),
        .I_jtag_halt(I_jtag_halt),
        .O_inst_valid(O_inst_valid), .O_inst(O_inst), .O_inst_addr(O_inst_addr),
        .O_inst_err(O_inst_err), .I_inst_ready(I_inst_ready),
        .O_ibus_req(O_ibus_req), .O_ibus_addr(O_ibus_addr), .I_ibus_gnt(I_ibus_gnt),
        .I_ibus_rvalid(I_ibus_rvalid), .I_ibus_rdata(I_ibus_rdata), .I_ibus_err(I_ibus_err)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    // Reference model: outstanding requests tagged stale/wanted, delivered entries in a plain queue.
    typedef struct packed { logic [31:0] addr; logic stale; } mreq_t;
    typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic err; } ment_t;

    mreq_t       mOut[$];
    ment_t       mFifo[$];
    logic [31:0] mFpc;
    logic        mHalt;
    logic [31:0] pend[$];
    logic        rspEn;
    logic        capReq;
    logic [31:0] capAddr;

    function automatic logic modelReq();
        int wanted = 0;
        foreach (mOut[i]) if (!mOut[i].stale) wanted++;
        return !mHalt && (mOut.size() < MAX_OUT) && (wanted + mFifo.size() < FIFO_DEPTH);
    endfunction

    task automatic modelReset();
        mOut.delete();
        mFifo.delete();
        mFpc  = RESET_PC;
        mHalt = 1'b1;
    endtask

    task automatic modelStep();
        logic  redir, g;
        mreq_t r;
        ment_t e;
        redir = I_flush || I_bru_taken;
        g     = modelReq() && I_ibus_gnt;
        if (!redir && mFifo.size() > 0 && I_inst_ready) void'(mFifo.pop_front());
        if (I_ibus_rvalid && mOut.size() > 0) begin
            r = mOut.pop_front();
            if (!r.stale && !redir) begin
                e.inst = memWord(r.addr);
                e.pc   = r.addr;
`ifdef IFETCH_ERR_EN
                e.err  = (r.addr == ERR_PC);
`else
                e.err  = 1'b0;
`endif
                mFifo.push_back(e);
            end
        end
        if (g) begin
            r.addr  = mFpc;
            r.stale = redir;
            mOut.push_back(r);
        end
        if (redir) begin
            foreach (mOut[i]) mOut[i].stale = 1'b1;
            mFifo.delete();
            mFpc = (I_flush ? I_flush_addr : I_bru_target) & ~32'h3;
        end else if (g) begin
            mFpc = mFpc + 32'd4;
        end
        mHalt = I_jtag_halt;
    endtask

    // Compare process plus in-order bus responder; checks at negedge, model advances at posedge.
    initial begin
        logic expReq;
        modelReset();
        I_ibus_rvalid = 1'b0;
        I_ibus_rdata  = '0;
        I_ibus_err    = 1'b0;
        capReq        = 1'b0;
        capAddr       = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                expReq = modelReq();
                checkOutput("ibus_req", 32'(O_ibus_req), 32'(expReq));
                if (expReq) checkOutput("ibus_addr", O_ibus_addr, mFpc);
                checkOutput("inst_valid", 32'(O_inst_valid), 32'(mFifo.size() > 0));
                if (mFifo.size() > 0) begin
                    checkOutput("inst", O_inst, mFifo[0].inst);
                    checkOutput("inst_addr", O_inst_addr, mFifo[0].pc);
                    checkOutput("inst_err", 32'(O_inst_err), 32'(mFifo[0].err));
                end
                capReq  = O_ibus_req;
                capAddr = O_ibus_addr;
            end else begin
                capReq = 1'b0;
            end
            #3;
            if (rst_n && rspEn && pend.size() > 0) begin
                I_ibus_rvalid = 1'b1;
                I_ibus_rdata  = memWord(pend[0]);
                I_ibus_err    = (pend[0] == ERR_PC);
            end else begin
                I_ibus_rvalid = 1'b0;
                I_ibus_rdata  = '0;
                I_ibus_err    = 1'b0;
            end
            @(posedge clk);
            if (!rst_n) begin
                modelReset();
                pend.delete();
            end else begin
                modelStep();
                if (I_ibus_rvalid) void'(pend.pop_front());
                if (capReq && I_ibus_gnt) pend.push_back(capAddr);
            end
        end
    end

    // Starts a new cycle: waits for the negedge, then drives this cycle's inputs.
    task automatic applyStimulus(input logic fl, input logic [31:0] fa, input logic bt,
                                 input logic [31:0] ba, input logic hl, input logic rdy,
                                 input logic gn, input logic rs);
        @(negedge clk);
        #1;
        I_flush      = fl;
        I_flush_addr = fa;
        I_bru_taken  = bt;
        I_bru_target = ba;
        I_jtag_halt  = hl;
        I_inst_ready = rdy;
        I_ibus_gnt   = gn;
        rspEn        = rs;
    endtask

    task automatic stream();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic drainIdle();
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("drain_empty", 32'(O_inst_valid), 32'd0);
    endtask

    initial begin
        int   grants, pops;
        logic expErr;
        rst_n = 1'b0;
        I_flush = 1'b0; I_flush_addr = '0; I_bru_taken = 1'b0; I_bru_target = '0;
        I_jtag_halt = 1'b0; I_inst_ready = 1'b0; I_ibus_gnt = 1'b0; rspEn = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(O_inst_valid), 32'd0);
        checkOutput("rst_inst", O_inst, 32'd0);
        checkOutput("rst_inst_addr", O_inst_addr, 32'd0);
        checkOutput("rst_inst_err", 32'(O_inst_err), 32'd0);
        checkOutput("rst_req", 32'(O_ibus_req), 32'd0);

        // Streaming fetch from RESET_PC, one instruction per cycle.
        stream();
        rst_n = 1'b1;
        checkOutput("release_req", 32'(O_ibus_req), 32'd0);
        stream();
        checkOutput("first_req", 32'(O_ibus_req), 32'd1);
        checkOutput("first_addr", O_ibus_addr, RESET_PC);
        stream();
        checkOutput("first_lat_valid", 32'(O_inst_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            stream();
`ifdef IFETCH_ERR_EN
            expErr = (i == 2);
`else
            expErr = 1'b0;
`endif
            checkOutput("stream_valid", 32'(O_inst_valid), 32'd1);
            checkOutput("stream_addr", O_inst_addr, RESET_PC + 32'(4 * i));
            checkOutput("stream_err", 32'(O_inst_err), 32'(expErr));
        end
        drainIdle();

        // Back-pressure: decode stalls, FIFO fills with exactly FIFO_DEPTH grants.
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (O_ibus_req) grants++;
        end
        checkOutput("bp_grants", 32'(grants), 32'd4);
        checkOutput("bp_req_low", 32'(O_ibus_req), 32'd0);
        checkOutput("bp_full_valid", 32'(O_inst_valid), 32'd1);
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (O_inst_valid) pops++;
        end
        checkOutput("bp_pops", 32'(pops), 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_drained", 32'(O_inst_valid), 32'd0);

        // Flush to an unaligned target with two requests in flight.
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0102, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("fl_two_inflight", 32'(O_ibus_req), 32'd0);
        stream();
        checkOutput("fl_req", 32'(O_ibus_req), 32'd1);
        checkOutput("fl_req_addr", O_ibus_addr, 32'h8000_0100);
        checkOutput("fl_valid_r1", 32'(O_inst_valid), 32'd0);
        stream();
        checkOutput("fl_valid_r2", 32'(O_inst_valid), 32'd0);
        stream();
        checkOutput("fl_valid_r3", 32'(O_inst_valid), 32'd1);
        checkOutput("fl_first_addr", O_inst_addr, 32'h8000_0100);
        drainIdle();

        // Flush and branch together while a grant and a pop happen.
        repeat (4) stream();
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("sim_pop_pending", 32'(O_inst_valid), 32'd1);
        checkOutput("sim_grant_pending", 32'(O_ibus_req), 32'd1);
        stream();
        checkOutput("sim_req_addr", O_ibus_addr, 32'h0000_0100);
        checkOutput("sim_valid_r1", 32'(O_inst_valid), 32'd0);
        stream();
        checkOutput("sim_valid_r2", 32'(O_inst_valid), 32'd0);
        stream();
        checkOutput("sim_first_addr", O_inst_addr, 32'h0000_0100);
        stream();
        checkOutput("sim_second_addr", O_inst_addr, 32'h0000_0104);
        drainIdle();

        // Halt with two outstanding: in-flight work completes, issue resumes sequentially.
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("halt_req0_addr", O_ibus_addr, 32'h0000_1000);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("halt_req1_addr", O_ibus_addr, 32'h0000_1004);
        grants = 0;
        pops   = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, (i < 5), 1'b1, 1'b1, 1'b1);
            if (O_ibus_req) grants++;
            if (O_inst_valid) pops++;
        end
        checkOutput("halt_grants", 32'(grants), 32'd0);
        checkOutput("halt_pops", 32'(pops), 32'd2);
        stream();
        checkOutput("halt_resume_req", 32'(O_ibus_req), 32'd1);
        checkOutput("halt_resume_addr", O_ibus_addr, 32'h0000_1008);

        // Reset asserted mid-stream drops everything at once.
        repeat (3) stream();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(O_inst_valid), 32'd0);
        checkOutput("midrst_req", 32'(O_ibus_req), 32'd0);
        checkOutput("midrst_inst_addr", O_inst_addr, 32'd0);
        repeat (2) stream();
        rst_n = 1'b1;
        stream();
        checkOutput("midrst_restart_addr", O_ibus_addr, RESET_PC);
        repeat (6) stream();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
